touch_sense: RTL and testbench
==============================

TOUCH_SENSE -- requirements
Module: touch_sense

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 480000, stable-input cycles required to accept a press or release (10 ms at 48 MHz); legal range >= 2.
REQ-002 Parameter LONG_CYCLES, default 48000000, held cycles after an accepted press before a long-press event (1 s); SHALL exceed DEBOUNCE_CYCLES.
REQ-003 clk  input  1  48 MHz system clock (globally buffered); the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 touch_n  input  2  raw pad inputs, asynchronous, active-low (pulled up; a touch bridges to the companion pad driven 0); bit0 = pad user_1, bit1 = pad user_4.
REQ-006 pressed  output  2  debounced level per pad, 1 = touched.
REQ-007 press_pulse  output  2  one-cycle strobe per accepted press.
REQ-008 release_pulse  output  2  one-cycle strobe per accepted release.
REQ-009 short_pulse  output  2  one-cycle strobe on release when no long event fired for that press.
REQ-010 long_pulse  output  2  one-cycle strobe when a press has been held LONG_CYCLES.
REQ-011 toggle  output  2  per-pad latch, inverts on every short press.

Function
REQ-012 Each bit of touch_n SHALL pass a 2-flop synchronizer (reset value 1) before any use; channels are fully independent.
REQ-013 Each channel SHALL implement states IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE.
REQ-014 IDLE: synchronized input 0 -> DEB_PRESS, debounce count cleared.
REQ-015 DEB_PRESS: input 1 -> IDLE (glitch discarded, no output); input 0 with count == DEBOUNCE_CYCLES-1 -> HELD, hold count cleared, press_pulse high next cycle, pressed set; else count+1.
REQ-016 HELD: input 0 -> hold count+1; hold count == LONG_CYCLES-1 -> LONG_HELD, long_pulse high next cycle; input 1 -> DEB_RELEASE, debounce count cleared, return-state HELD recorded.
REQ-017 LONG_HELD: input 1 -> DEB_RELEASE, return-state LONG_HELD recorded; hold count frozen; no further long_pulse for this press.
REQ-018 DEB_RELEASE: input 0 -> recorded return-state, hold count not cleared; input 1 with count == DEBOUNCE_CYCLES-1 -> IDLE, pressed cleared, release_pulse high next cycle; short_pulse and toggle inversion in that same cycle only if return-state was HELD.
REQ-019 Hold count SHALL NOT advance in DEB_RELEASE; a press interrupted by a rejected release glitch resumes its hold count.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter; counters never wrap (state leaves before terminal value is exceeded).
REQ-021 press_pulse and release_pulse of one channel SHALL never coincide; long_pulse and short_pulse SHALL never both occur for one press.
REQ-022 All outputs SHALL be registered; no combinational path from touch_n to any output.
REQ-023 Latency: press_pulse rises exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge sampling touch_n low, given a clean step.

Reset
REQ-024 On rst: all channels IDLE, counters 0, synchronizers 1, pressed/press_pulse/release_pulse/short_pulse/long_pulse/toggle = 0.
REQ-025 rst asserted mid-press SHALL discard the press with no release/short pulse; a pad still held after rst releases SHALL be re-debounced from IDLE and produce a fresh press_pulse.

Structure
REQ-026 Shared package touch_pkg SHALL hold the channel state enum, NUM_PADS = 2, and the default DEBOUNCE_CYCLES/LONG_CYCLES constants.
REQ-027 One sub-module touch_channel (synchronizer, FSM, counters, per-pad outputs) SHALL be instantiated NUM_PADS times; top of block is wiring only.

Verification (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-028 touch_n[0] low 10 cycles then high -> press_pulse[0] once at cycle 7, release_pulse[0], short_pulse[0] once, toggle[0] 0->1; channel 1 silent.
REQ-029 touch_n[1] low 2 cycles then high -> no pulses, pressed stays 0.
REQ-030 touch_n[0] low 30 cycles -> one press_pulse, one long_pulse 16 cycles after press_pulse; on release, release_pulse only, no short_pulse, toggle unchanged.
REQ-031 Held press with 2-cycle high glitch -> no release_pulse, pressed stays 1, long_pulse delayed by only the glitch-plus-sync cycles.
REQ-032 rst for 1 cycle while pad held in HELD -> all outputs 0, no release_pulse; pad still low -> new press_pulse 7 cycles after rst deasserts.
REQ-033 Both pads pressed simultaneously, same pattern -> identical, cycle-aligned pulses on both bits.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and defaults for the capacitive touch-pad front end.
package touch_pkg;

    // Number of touch pads handled by touch_sense.
    localparam int unsigned NUM_PADS = 2;

    // 10 ms debounce and 1 s long-press at a 48 MHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 480000;
    localparam int unsigned LONG_CYCLES_DEF     = 48000000;

    // Per-channel press tracking state.
    typedef enum logic [2:0] {
        StIdle,
        StDebPress,
        StHeld,
        StLongHeld,
        StDebRelease
    } touch_state_e;

endpackage

// File: rtl/touch_channel.sv
// One touch pad: input synchronizer, debounce/hold FSM and registered event outputs.
module touch_channel
    import touch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic touch_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic short_pulse_o,
    output logic long_pulse_o,
    output logic toggle_o
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = $clog2(LONG_CYCLES);
    localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             in_n;
    touch_state_e     state_q, state_d;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    // Remembers whether a release debounce interrupted a press that already went long.
    logic             ret_long_q, ret_long_d;

    logic ev_press_d, ev_release_d, ev_short_d, ev_long_d;
    logic ev_press_q, ev_release_q, ev_short_q, ev_long_q;

    logic pressed_q, press_pulse_q, release_pulse_q, short_pulse_q, long_pulse_q, toggle_q;

    // Two-flop synchronizer; idles high so reset looks like an untouched pad.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], touch_n_i};
        end
    end

    assign in_n = sync_q[1];

    // Next-state, counter and event decode.
    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        ret_long_d   = ret_long_q;
        ev_press_d   = 1'b0;
        ev_release_d = 1'b0;
        ev_short_d   = 1'b0;
        ev_long_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!in_n) begin
                    state_d   = StDebPress;
                    deb_cnt_d = '0;
                end
            end
            StDebPress: begin
                if (in_n) begin
                    state_d = StIdle;
                end else if (deb_cnt_q == DebLast) begin
                    state_d    = StHeld;
                    hold_cnt_d = '0;
                    ev_press_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (in_n) begin
                    state_d    = StDebRelease;
                    deb_cnt_d  = '0;
                    ret_long_d = 1'b0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d   = StLongHeld;
                    ev_long_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StLongHeld: begin
                if (in_n) begin
                    state_d    = StDebRelease;
                    deb_cnt_d  = '0;
                    ret_long_d = 1'b1;
                end
            end
            StDebRelease: begin
                // Hold count is left untouched so a rejected release resumes the press.
                if (!in_n) begin
                    state_d = ret_long_q ? StLongHeld : StHeld;
                end else if (deb_cnt_q == DebLast) begin
                    state_d      = StIdle;
                    ev_release_d = 1'b1;
                    ev_short_d   = !ret_long_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, counters and the one-cycle event stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            ret_long_q   <= 1'b0;
            ev_press_q   <= 1'b0;
            ev_release_q <= 1'b0;
            ev_short_q   <= 1'b0;
            ev_long_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            ret_long_q   <= ret_long_d;
            ev_press_q   <= ev_press_d;
            ev_release_q <= ev_release_d;
            ev_short_q   <= ev_short_d;
            ev_long_q    <= ev_long_d;
        end
    end

    // Registered user-facing outputs, driven one cycle after the state transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            short_pulse_q   <= 1'b0;
            long_pulse_q    <= 1'b0;
            toggle_q        <= 1'b0;
        end else begin
            if (ev_press_q) begin
                pressed_q <= 1'b1;
            end else if (ev_release_q) begin
                pressed_q <= 1'b0;
            end
            press_pulse_q   <= ev_press_q;
            release_pulse_q <= ev_release_q;
            short_pulse_q   <= ev_short_q;
            long_pulse_q    <= ev_long_q;
            toggle_q        <= toggle_q ^ ev_short_q;
        end
    end

    assign pressed_o       = pressed_q;
    assign press_pulse_o   = press_pulse_q;
    assign release_pulse_o = release_pulse_q;
    assign short_pulse_o   = short_pulse_q;
    assign long_pulse_o    = long_pulse_q;
    assign toggle_o        = toggle_q;

endmodule

// File: rtl/touch_sense.sv
// Touch-pad front end: one independent touch_channel per pad, wiring only.
module touch_sense
    import touch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PADS-1:0] touch_n,
    output logic [NUM_PADS-1:0] pressed,
    output logic [NUM_PADS-1:0] press_pulse,
    output logic [NUM_PADS-1:0] release_pulse,
    output logic [NUM_PADS-1:0] short_pulse,
    output logic [NUM_PADS-1:0] long_pulse,
    output logic [NUM_PADS-1:0] toggle
);

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        touch_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_channel (
            .clk_i           (clk),
            .rst_i           (rst),
            .touch_n_i       (touch_n[i]),
            .pressed_o       (pressed[i]),
            .press_pulse_o   (press_pulse[i]),
            .release_pulse_o (release_pulse[i]),
            .short_pulse_o   (short_pulse[i]),
            .long_pulse_o    (long_pulse[i]),
            .toggle_o        (toggle[i])
        );
    end

endmodule

// File: tb/tb_touch_sense.sv
// Directed bench for touch_sense with a pulse scoreboard (DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
module tb_touch_sense;

    localparam int KPress   = 0;
    localparam int KRelease = 1;
    localparam int KShort   = 2;
    localparam int KLong    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] touch_n;
    logic [1:0] pressed, press_pulse, release_pulse, short_pulse, long_pulse, toggle;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    int exp_q[$];

    touch_sense #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .touch_n       (touch_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .toggle        (toggle)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            KPress:   return "press";
            KRelease: return "release";
            KShort:   return "short";
            default:  return "long";
        endcase
    endfunction

    task automatic expect_evt(input int kind, input int pad, input int at);
        exp_q.push_back(at * 8 + kind * 2 + pad);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Any asserted pulse must match a scheduled event for this pad and cycle.
    task automatic observe(input int kind, input int pad, input logic val);
        int  key;
        int  idx;
        bit  found;
        if (val !== 1'b0) begin
            key   = cyc * 8 + kind * 2 + pad;
            found = 1'b0;
            idx   = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i] == key) begin
                    found = 1'b1;
                    idx   = i;
                    break;
                end
            end
            if (found) exp_q.delete(idx);
            checks++;
            assert (found === 1'b1) else begin
                failures++;
                $error("FAIL %s_pulse pad=%0d cyc=%0d observed=%b expected=no_pulse",
                       kind_name(kind), pad, cyc, val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < 2; p++) begin
                observe(KPress, p, press_pulse[p]);
                observe(KRelease, p, release_pulse[p]);
                observe(KShort, p, short_pulse[p]);
                observe(KLong, p, long_pulse[p]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        touch_n = 2'b11;
        step(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        check_val("reset_pressed", 32'(pressed), 32'h0);
        check_val("reset_toggle", 32'(toggle), 32'h0);
        check_val("reset_pulses", 32'({press_pulse, release_pulse, short_pulse, long_pulse}), 32'h0);
        step(3);

        // Clean short press on pad 0.
        n = cyc;
        touch_n[0] = 1'b0;
        expect_evt(KPress, 0, n + 8);
        expect_evt(KRelease, 0, n + 18);
        expect_evt(KShort, 0, n + 18);
        step(10);
        check_val("short_pressed_held", 32'(pressed), 32'h1);
        touch_n[0] = 1'b1;
        step(8);
        check_val("short_pressed_after", 32'(pressed), 32'h0);
        check_val("short_toggle", 32'(toggle), 32'h1);
        step(4);

        // Too-brief touch on pad 1 is discarded.
        touch_n[1] = 1'b0;
        step(2);
        touch_n[1] = 1'b1;
        step(3);
        check_val("glitch_pressed", 32'(pressed), 32'h0);
        step(8);
        check_val("glitch_toggle", 32'(toggle), 32'h1);

        // Long press on pad 0.
        n = cyc;
        touch_n[0] = 1'b0;
        expect_evt(KPress, 0, n + 8);
        expect_evt(KLong, 0, n + 24);
        expect_evt(KRelease, 0, n + 38);
        step(30);
        check_val("long_pressed_held", 32'(pressed), 32'h1);
        touch_n[0] = 1'b1;
        step(8);
        check_val("long_pressed_after", 32'(pressed), 32'h0);
        check_val("long_toggle", 32'(toggle), 32'h1);
        step(4);

        // Held press with a 2-cycle release glitch: long event slips by 3 cycles.
        n = cyc;
        touch_n[0] = 1'b0;
        expect_evt(KPress, 0, n + 8);
        expect_evt(KLong, 0, n + 27);
        expect_evt(KRelease, 0, n + 48);
        step(11);
        touch_n[0] = 1'b1;
        step(2);
        touch_n[0] = 1'b0;
        step(7);
        check_val("rglitch_pressed", 32'(pressed), 32'h1);
        step(20);
        touch_n[0] = 1'b1;
        step(8);
        check_val("rglitch_pressed_after", 32'(pressed), 32'h0);
        check_val("rglitch_toggle", 32'(toggle), 32'h1);
        step(4);

        // Reset while held: press discarded, re-debounced afterwards.
        n = cyc;
        touch_n[0] = 1'b0;
        expect_evt(KPress, 0, n + 8);
        step(12);
        check_val("rst_pressed_before", 32'(pressed), 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_val("rst_pressed", 32'(pressed), 32'h0);
        check_val("rst_toggle", 32'(toggle), 32'h0);
        check_val("rst_pulses", 32'({press_pulse, release_pulse, short_pulse, long_pulse}), 32'h0);
        expect_evt(KPress, 0, n + 21);
        step(17);
        check_val("rst_repress", 32'(pressed), 32'h1);
        touch_n[0] = 1'b1;
        expect_evt(KRelease, 0, n + 38);
        expect_evt(KShort, 0, n + 38);
        step(8);
        check_val("rst_toggle_after", 32'(toggle), 32'h1);
        step(4);

        // Both pads together, identical timing.
        n = cyc;
        touch_n = 2'b00;
        for (int p = 0; p < 2; p++) begin
            expect_evt(KPress, p, n + 8);
            expect_evt(KRelease, p, n + 18);
            expect_evt(KShort, p, n + 18);
        end
        step(10);
        check_val("both_pressed", 32'(pressed), 32'h3);
        touch_n = 2'b11;
        step(8);
        check_val("both_pressed_after", 32'(pressed), 32'h0);
        check_val("both_toggle", 32'(toggle), 32'h2);
        step(4);

        checks++;
        assert (exp_q.size() === 0) else begin
            failures++;
            $error("FAIL missing_pulses observed_pending=%0d expected=0 first_key=%0d",
                   exp_q.size(), exp_q[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
